// File: rtl/btn_event_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_gen_pkg
//  Purpose  : Shared definitions for the push-button conditioner: per-channel
//             state encodings and a constant-evaluable ceil(log2) helper.
//  Revision : 1.0 - initial release
// ============================================================================
package btn_event_gen_pkg;

    // Per-channel hold state: released, held waiting for first repeat,
    // held and repeating.
    typedef enum logic [1:0] {
        IDLE_LO  = 2'd0,
        HELD_DLY = 2'd1,
        HELD_RPT = 2'd2
    } chan_state_t;

    // ceil(log2(value)); value 1 yields 0. Used to size counters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_chan_cond.sv
`default_nettype none
// ============================================================================
//  Module   : btn_chan_cond
//  Purpose  : One button channel: synchroniser chain, debounce filter,
//             press/release pulse generation and optional auto-repeat.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_chan_cond
    import btn_event_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int RPT_EN      = 0,
    parameter int RPT_DELAY   = 1000,
    parameter int RPT_PERIOD  = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic rpt_pulse
);

    // Debounce counter is one bit wider than the terminal count needs so the
    // DB_CYCLES=1 case still has a legal vector width.
    localparam int                c_DB_W    = clog2(DB_CYCLES) + 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DB_W-1:0]      r_db_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_s;
    logic                   w_accept;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A level change is accepted on the cycle the synchronised input has
    // disagreed with the current level for DB_CYCLES consecutive cycles.
    assign w_accept = (w_s != r_level) && (r_db_cnt == c_DB_LAST);

    // Metastability chain: raw level shifts in at bit 0, leaves at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Debounce filter plus single-cycle press/release pulses on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_s == r_level) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_db_cnt  <= '0;
                r_level   <= w_s;
                r_press   <= w_s;
                r_release <= ~w_s;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign level         = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

    if (RPT_EN != 0) begin : g_rpt
        localparam int c_RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
        localparam int c_RPT_W   = (clog2(c_RPT_MAX) < 1) ? 1 : clog2(c_RPT_MAX);
        localparam logic [c_RPT_W-1:0] c_DLY_LAST = c_RPT_W'(RPT_DELAY - 1);
        localparam logic [c_RPT_W-1:0] c_PER_LAST = c_RPT_W'(RPT_PERIOD - 1);

        chan_state_t        r_state;
        logic [c_RPT_W-1:0] r_rpt_cnt;
        logic               r_rpt;
        logic               w_accept_rise;
        logic               w_accept_fall;

        assign w_accept_rise = w_accept & w_s;
        assign w_accept_fall = w_accept & ~w_s;

        // Hold-state FSM: a release always wins and suppresses any repeat
        // pulse due on the same cycle; counter restarts on every pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= IDLE_LO;
                r_rpt_cnt <= '0;
                r_rpt     <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (w_accept_fall) begin
                    r_state   <= IDLE_LO;
                    r_rpt_cnt <= '0;
                end else begin
                    case (r_state)
                        IDLE_LO: begin
                            if (w_accept_rise) begin
                                r_state   <= HELD_DLY;
                                r_rpt_cnt <= '0;
                            end
                        end
                        HELD_DLY: begin
                            if (r_rpt_cnt == c_DLY_LAST) begin
                                r_state   <= HELD_RPT;
                                r_rpt_cnt <= '0;
                                r_rpt     <= 1'b1;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + 1'b1;
                            end
                        end
                        HELD_RPT: begin
                            if (r_rpt_cnt == c_PER_LAST) begin
                                r_rpt_cnt <= '0;
                                r_rpt     <= 1'b1;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_state   <= IDLE_LO;
                            r_rpt_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign rpt_pulse = r_rpt;
    end else begin : g_no_rpt
        assign rpt_pulse = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/btn_event_gen.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_gen
//  Purpose  : Multi-channel push-button conditioner. Each channel is an
//             independent btn_chan_cond; outputs are concatenated by index.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_event_gen
    import btn_event_gen_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int RPT_EN      = 0,
    parameter int RPT_DELAY   = 1000,
    parameter int RPT_PERIOD  = 250
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] rpt_pulse
);

    // One fully independent conditioner per button.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_chan_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RPT_EN      (RPT_EN),
            .RPT_DELAY   (RPT_DELAY),
            .RPT_PERIOD  (RPT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_raw       (btn_raw[i]),
            .level         (level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .rpt_pulse     (rpt_pulse[i])
        );
    end

endmodule
`default_nettype wire
